// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared types, default widths and id-width helper for the multiplier arbiter
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DefNumReq        = 4;
    localparam int DefOperandALen   = 131;
    localparam int DefOperandBLen   = 127;
    localparam int DefResultLen     = 264;
    localparam int DefTimeoutCycles = 1024;

    function automatic int IdWidth(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after lastGrant_i
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter  int NumReq = DefNumReq,
    localparam int IdW    = IdWidth(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    lastGrant_i,
    output logic [NumReq-1:0] grantOh_o,
    output logic [IdW-1:0]    grantIdx_o,
    output logic              anyGrant_o
);

    int unsigned    cand;
    logic [IdW-1:0] candIdx;
    logic           found;

    always_comb begin
        grantOh_o  = '0;
        grantIdx_o = '0;
        anyGrant_o = 1'b0;
        cand       = 0;
        candIdx    = '0;
        found      = 1'b0;
        // offset 1..NumReq so the last winner is visited last
        for (int off = 1; off <= NumReq; off++) begin
            cand    = (int'(lastGrant_i) + off) % NumReq;
            candIdx = IdW'(cand);
            if (!found && req_i[candIdx]) begin
                found              = 1'b1;
                grantOh_o[candIdx] = 1'b1;
                grantIdx_o         = candIdx;
            end
        end
        anyGrant_o = found;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - shares one multiplier accelerator among NumReq requesters
// Optional watchdog in WAIT enabled by defining MULT_TIMEOUT_EN.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter  int NumReq        = DefNumReq,
    parameter  int OperandALen   = DefOperandALen,
    parameter  int OperandBLen   = DefOperandBLen,
    parameter  int ResultLen     = DefResultLen,
    parameter  int TimeoutCycles = DefTimeoutCycles,
    localparam int IdW           = IdWidth(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*OperandALen-1:0] req_a_i,
    input  logic [NumReq*OperandBLen-1:0] req_b_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [IdW-1:0]                rsp_id_o,
    output logic [ResultLen-1:0]          rsp_data_o,
    output logic                          rsp_err_o,
    output logic [OperandALen-1:0]        acc_a_o,
    output logic [OperandBLen-1:0]        acc_b_o,
    output logic                          acc_start_o,
    input  logic                          acc_done_i,
    input  logic [ResultLen-1:0]          acc_result_i
);

    state_e             state, nextState;
    logic [NumReq-1:0]  grantOh;
    logic [IdW-1:0]     grantIdx;
    logic               anyGrant;
    logic [IdW-1:0]     lastGrant;
    logic               timeoutHit;

    rr_arbiter #(.NumReq(NumReq)) rrArb (
        .req_i      (req_valid_i),
        .lastGrant_i(lastGrant),
        .grantOh_o  (grantOh),
        .grantIdx_o (grantIdx),
        .anyGrant_o (anyGrant)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState   = state;
        req_ready_o = '0;
        acc_start_o = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready_o = grantOh;
                if (anyGrant) nextState = ISSUE;
            end
            ISSUE: begin
                acc_start_o = 1'b1;
                nextState   = WAIT;
            end
            WAIT: if (acc_done_i || timeoutHit) nextState = RESP;
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // operands only move on a grant, keeping them stable for the whole job
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_a_o    <= '0;
            acc_b_o    <= '0;
            rsp_id_o   <= '0;
            rsp_data_o <= '0;
            lastGrant  <= IdW'(NumReq - 1);
        end else begin
            if (state == IDLE && anyGrant) begin
                acc_a_o  <= req_a_i[grantIdx*OperandALen +: OperandALen];
                acc_b_o  <= req_b_i[grantIdx*OperandBLen +: OperandBLen];
                rsp_id_o <= grantIdx;
            end
            if (state == WAIT && acc_done_i)  rsp_data_o <= acc_result_i;
            else if (timeoutHit)              rsp_data_o <= '0;
            if (state == RESP && rsp_ready_i) lastGrant  <= rsp_id_o;
        end
    end

`ifdef MULT_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles) + 1;

    logic [CntW-1:0] waitCnt;
    logic            errReg;

    assign timeoutHit = (state == WAIT) && (waitCnt == CntW'(TimeoutCycles - 1));
    assign rsp_err_o  = errReg;

    // done in the same cycle as the watchdog expiry wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            waitCnt <= '0;
            errReg  <= 1'b0;
        end else begin
            if (state == ISSUE)     waitCnt <= '0;
            else if (state == WAIT) waitCnt <= waitCnt + CntW'(1);
            if (state == WAIT && acc_done_i) errReg <= 1'b0;
            else if (timeoutHit)             errReg <= 1'b1;
        end
    end
`else
    logic unusedTimeout;

    assign timeoutHit    = 1'b0;
    assign rsp_err_o     = 1'b0;
    assign unusedTimeout = ^TimeoutCycles;
`endif

endmodule
